cw305_usb_host: RTL and testbench

- Synthesizable initiator for the CW305 SAM3U-style parallel USB register bus. It is the host side of the bus whose responder lives inside cw305_top.
- Turns valid/ready register requests (1..4 bytes, read or write) into timed usb_cen/usb_addr/usb_wrn/usb_rdn/usb_data cycles and returns a completion.
- Used in the simulation wrapper and on-chip self-test to drive register traffic without an external host.

---
 rtl/cw305_usb_host_pkg.sv | 23 ++
 rtl/cw305_usb_phase_cnt.sv | 26 ++
 rtl/cw305_usb_host.sv | 217 +++++++++++++++++++++
 tb/tb_cw305_usb_host.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_usb_host_pkg.sv
// Shared types and defaults for the CW305 parallel USB register-bus initiator.
// Consumed by cw305_usb_host and its phase counter.
package cw305_usb_host_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int DEF_ADDR_WIDTH   = 21;
    localparam int DEF_BYTECNT_SIZE = 2;
    localparam int DEF_SETUP_CYC    = 1;
    localparam int DEF_STROBE_CYC   = 2;
    localparam int DEF_HOLD_CYC     = 1;

    function automatic int bytes_per_reg(input int bytecnt_size);
        return 1 << bytecnt_size;
    endfunction

endpackage

// File: rtl/cw305_usb_phase_cnt.sv
// Loadable down-counter that times one bus phase; zero_o marks the phase's last cycle.
module cw305_usb_phase_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/cw305_usb_host.sv
// Initiator for the CW305 SAM3U-style parallel USB register bus (valid/ready in, timed strobes out).
// Define CW305_USB_HOST_TRIGGER_EN to add req_trig_i / usb_trigger_o.
module cw305_usb_host
    import cw305_usb_host_pkg::*;
#(
    parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = DEF_BYTECNT_SIZE,
    parameter int SETUP_CYC     = DEF_SETUP_CYC,
    parameter int STROBE_CYC    = DEF_STROBE_CYC,
    parameter int HOLD_CYC      = DEF_HOLD_CYC
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]  req_reg_i,
    input  logic [pBYTECNT_SIZE-1:0]              req_nbytes_i,
    input  logic [8*(2**pBYTECNT_SIZE)-1:0]       req_wdata_i,
`ifdef CW305_USB_HOST_TRIGGER_EN
    input  logic                                  req_trig_i,
    output logic                                  usb_trigger_o,
`endif
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [8*(2**pBYTECNT_SIZE)-1:0]       rsp_rdata_o,
    output logic [pADDR_WIDTH-1:0]                usb_addr_o,
    output logic [7:0]                            usb_data_o,
    output logic                                  usb_data_oe_o,
    input  logic [7:0]                            usb_data_i,
    output logic                                  usb_cen_o,
    output logic                                  usb_wrn_o,
    output logic                                  usb_rdn_o,
    output logic                                  busy_o
);

    localparam int DATA_W  = 8 * bytes_per_reg(pBYTECNT_SIZE);
    localparam int REG_W   = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t                     r_state, w_state_nxt;
    logic                       r_we;
    logic [REG_W-1:0]           r_reg;
    logic [pBYTECNT_SIZE-1:0]   r_nbytes;
    logic [DATA_W-1:0]          r_wdata;
    logic [DATA_W-1:0]          r_rdata;
    logic [pBYTECNT_SIZE-1:0]   r_idx, w_idx_nxt;

    logic                       w_accept;
    logic                       w_cnt_load;
    logic [CNT_W-1:0]           w_cnt_val;
    logic                       w_cnt_zero;

    logic                       w_we_nxt;
    logic [REG_W-1:0]           w_reg_nxt;
    logic [DATA_W-1:0]          w_wdata_nxt;
    logic                       w_in_cycle;
    logic                       w_cen_nxt, w_wrn_nxt, w_rdn_nxt, w_oe_nxt;
    logic [pADDR_WIDTH-1:0]     w_addr_nxt;
    logic [7:0]                 w_data_nxt;

    logic                       r_usb_cen, r_usb_wrn, r_usb_rdn, r_usb_oe;
    logic [pADDR_WIDTH-1:0]     r_usb_addr;
    logic [7:0]                 r_usb_data;

    assign w_accept = req_valid_i && (r_state == IDLE);

    cw305_usb_phase_cnt #(.WIDTH(CNT_W)) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_val),
        .zero_o     (w_cnt_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state_nxt = SETUP;
                w_idx_nxt   = '0;
                w_cnt_load  = 1'b1;
                w_cnt_val   = SETUP_LD;
            end
            SETUP: if (w_cnt_zero) begin
                w_state_nxt = STROBE;
                w_cnt_load  = 1'b1;
                w_cnt_val   = STROBE_LD;
            end
            STROBE: if (w_cnt_zero) begin
                w_state_nxt = HOLD;
                w_cnt_load  = 1'b1;
                w_cnt_val   = HOLD_LD;
            end
            HOLD: if (w_cnt_zero) begin
                if (r_idx == r_nbytes) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = SETUP;
                    w_idx_nxt   = r_idx + pBYTECNT_SIZE'(1);
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = SETUP_LD;
                end
            end
            RESP: if (rsp_ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request context; rdata is cleared on accept and filled byte by byte on the last strobe cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we     <= 1'b0;
            r_reg    <= '0;
            r_nbytes <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_idx    <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_accept) begin
                r_we     <= req_we_i;
                r_reg    <= req_reg_i;
                r_nbytes <= req_nbytes_i;
                r_wdata  <= req_wdata_i;
                r_rdata  <= '0;
            end else if (r_state == STROBE && w_cnt_zero && !r_we) begin
                r_rdata[{r_idx, 3'b000} +: 8] <= usb_data_i;
            end
        end
    end

    // Bus outputs are computed from the next state so the registered pins line up with the phase.
    always_comb begin
        w_we_nxt    = w_accept ? req_we_i    : r_we;
        w_reg_nxt   = w_accept ? req_reg_i   : r_reg;
        w_wdata_nxt = w_accept ? req_wdata_i : r_wdata;
        w_in_cycle  = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) || (w_state_nxt == HOLD);
        w_cen_nxt   = !w_in_cycle;
        w_wrn_nxt   = !((w_state_nxt == STROBE) && w_we_nxt);
        w_rdn_nxt   = !((w_state_nxt == STROBE) && !w_we_nxt);
        w_oe_nxt    = w_in_cycle && w_we_nxt;
        w_addr_nxt  = r_usb_addr;
        w_data_nxt  = r_usb_data;
        if (w_state_nxt == SETUP) begin
            w_addr_nxt = {w_reg_nxt, w_idx_nxt};
            w_data_nxt = w_we_nxt ? w_wdata_nxt[{w_idx_nxt, 3'b000} +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_usb_cen  <= 1'b1;
            r_usb_wrn  <= 1'b1;
            r_usb_rdn  <= 1'b1;
            r_usb_oe   <= 1'b0;
            r_usb_addr <= '0;
            r_usb_data <= '0;
        end else begin
            r_usb_cen  <= w_cen_nxt;
            r_usb_wrn  <= w_wrn_nxt;
            r_usb_rdn  <= w_rdn_nxt;
            r_usb_oe   <= w_oe_nxt;
            r_usb_addr <= w_addr_nxt;
            r_usb_data <= w_data_nxt;
        end
    end

`ifdef CW305_USB_HOST_TRIGGER_EN
    logic r_trig;
    logic r_usb_trigger;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_trig        <= 1'b0;
            r_usb_trigger <= 1'b0;
        end else begin
            if (w_accept) r_trig <= req_trig_i;
            r_usb_trigger <= w_in_cycle && (w_accept ? req_trig_i : r_trig);
        end
    end

    assign usb_trigger_o = r_usb_trigger;
`endif

    assign req_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign rsp_valid_o   = (r_state == RESP);
    assign rsp_rdata_o   = r_rdata;
    assign usb_cen_o     = r_usb_cen;
    assign usb_wrn_o     = r_usb_wrn;
    assign usb_rdn_o     = r_usb_rdn;
    assign usb_data_oe_o = r_usb_oe;
    assign usb_addr_o    = r_usb_addr;
    assign usb_data_o    = r_usb_data;

endmodule

// File: tb/tb_cw305_usb_host.sv
// Self-checking bench for cw305_usb_host: bus-cycle checks per transfer plus a response scoreboard.
// Define CW305_USB_HOST_TRIGGER_EN to also exercise the trigger output.
module tb_cw305_usb_host;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [18:0] req_reg;
    logic [1:0]  req_nbytes;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [20:0] usb_addr;
    logic [7:0]  usb_data;
    logic        usb_oe;
    logic [7:0]  usb_data_in;
    logic        usb_cen, usb_wrn, usb_rdn;
    logic        busy;
`ifdef CW305_USB_HOST_TRIGGER_EN
    logic        req_trig;
    logic        usb_trigger;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    cw305_usb_host dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_reg_i    (req_reg),
        .req_nbytes_i (req_nbytes),
        .req_wdata_i  (req_wdata),
`ifdef CW305_USB_HOST_TRIGGER_EN
        .req_trig_i   (req_trig),
        .usb_trigger_o(usb_trigger),
`endif
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .usb_addr_o   (usb_addr),
        .usb_data_o   (usb_data),
        .usb_data_oe_o(usb_oe),
        .usb_data_i   (usb_data_in),
        .usb_cen_o    (usb_cen),
        .usb_wrn_o    (usb_wrn),
        .usb_rdn_o    (usb_rdn),
        .busy_o       (busy)
    );

    // Responder model: each register byte reads back as 0x10 plus its byte index.
    assign usb_data_in = 8'h10 + {6'b0, usb_addr[1:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rdata(input int nb);
        logic [31:0] r = '0;
        for (int i = 0; i <= nb; i++) r[8*i +: 8] = 8'h10 + 8'(i);
        return r;
    endfunction

    // Scoreboard: pop one expectation per completion handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", {63'b0, rsp_valid}, 64'd0);
            else check("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, exp_q.pop_front()});
        end
    end

    task automatic send(input bit we, input logic [18:0] rg, input logic [1:0] nb,
                        input logic [31:0] wd, input bit trig, input bit exp_rsp,
                        input logic [31:0] exp_rd);
        int n = 0;
        while (!req_ready && n < 200) begin step(); n++; end
        if (n == 200) check("send_timeout", {63'b0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_reg    = rg;
        req_nbytes = nb;
        req_wdata  = wd;
`ifdef CW305_USB_HOST_TRIGGER_EN
        req_trig   = trig;
`else
        if (trig) $display("note: trigger flag ignored in this build");
`endif
        if (exp_rsp) exp_q.push_back(exp_rd);
        step();
        req_valid = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; returns in the rsp_valid cycle.
    task automatic watch_xfer(input string tag, input bit we, input logic [18:0] rg,
                              input int nb, input logic [31:0] wd, input bit trig);
        int          n_cyc;
        int          b, p;
        logic        strb;
        logic        trig_act;
        logic [63:0] act, exp;
        n_cyc = (nb + 1) * 4;
        for (int c = 1; c <= n_cyc; c++) begin
            b    = (c - 1) / 4;
            p    = (c - 1) % 4;
            strb = (p == 1) || (p == 2);
`ifdef CW305_USB_HOST_TRIGGER_EN
            trig_act = usb_trigger;
`else
            trig_act = 1'b0;
`endif
            act = {29'b0, rsp_valid, usb_cen, usb_wrn, usb_rdn, usb_oe, usb_addr,
                   (we ? usb_data : 8'h00), trig_act};
            exp = {29'b0, 1'b0, 1'b0, !(we && strb), !(!we && strb), we, rg, b[1:0],
                   (we ? wd[8*b +: 8] : 8'h00), trig};
            check($sformatf("%s_c%0d", tag, c), act, exp);
            step();
        end
`ifdef CW305_USB_HOST_TRIGGER_EN
        trig_act = usb_trigger;
`else
        trig_act = 1'b0;
`endif
        check({tag, "_resp"}, {58'b0, rsp_valid, usb_cen, usb_wrn, usb_rdn, usb_oe, trig_act},
              64'b111100);
    endtask

    initial begin
        int n_acc, first_done, second_acc;
        logic cen_gap;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_reg    = '0;
        req_nbytes = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
`ifdef CW305_USB_HOST_TRIGGER_EN
        req_trig   = 1'b0;
`endif
        repeat (3) step();
        check("reset_ctl", {57'b0, req_ready, busy, rsp_valid, usb_cen, usb_wrn, usb_rdn, usb_oe},
              64'b1001110);
        check("reset_addr", {43'b0, usb_addr}, 64'd0);
        check("reset_data", {24'b0, usb_data, rsp_rdata}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single-byte write.
        send(1'b1, 19'h05, 2'd0, 32'h0000_00A5, 1'b0, 1'b1, 32'h0);
        watch_xfer("wr1", 1'b1, 19'h05, 0, 32'h0000_00A5, 1'b0);
        step();

        // Four-byte read; completion at cycle 17.
        send(1'b0, 19'h03, 2'd3, 32'h0, 1'b0, 1'b1, model_rdata(3));
        watch_xfer("rd4", 1'b0, 19'h03, 3, 32'h0, 1'b0);
        step();

        // Backpressure on a two-byte read.
        rsp_ready = 1'b0;
        send(1'b0, 19'h07, 2'd1, 32'h0, 1'b0, 1'b1, model_rdata(1));
        watch_xfer("bp", 1'b0, 19'h07, 1, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), {29'b0, rsp_valid, req_ready, usb_cen, rsp_rdata},
                  {29'b0, 1'b1, 1'b0, 1'b1, model_rdata(1)});
            if (i < 9) step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_idle", {61'b0, req_ready, busy, rsp_valid}, 64'b100);

        // Back-to-back writes with valid held high.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_reg    = 19'h0A;
        req_nbytes = 2'd0;
        req_wdata  = 32'h0000_005A;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        n_acc      = 0;
        first_done = -1;
        second_acc = -1;
        cen_gap    = 1'b0;
        for (int c = 0; c < 40 && second_acc < 0; c++) begin
            if (req_ready) begin
                n_acc++;
                if (n_acc == 2) begin
                    second_acc = c;
                    cen_gap    = usb_cen;
                end
            end
            if (rsp_valid && first_done < 0) first_done = c;
            step();
        end
        req_valid = 1'b0;
        check("b2b_gap", 64'(second_acc - first_done), 64'd1);
        check("b2b_cen", {63'b0, cen_gap}, 64'd1);
        for (int c = 0; c < 40 && !rsp_valid; c++) step();
        check("b2b_second_rsp", {63'b0, rsp_valid}, 64'd1);
        step();

        // Asynchronous reset in the middle of a three-byte write.
        send(1'b1, 19'h02, 2'd2, 32'h0033_2211, 1'b0, 1'b0, 32'h0);
        step();
        check("rst_pre", {61'b0, usb_cen, usb_wrn, usb_oe}, 64'b001);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {57'b0, usb_cen, usb_wrn, usb_rdn, usb_oe, rsp_valid, busy, req_ready},
              64'b1110001);
        repeat (2) step();
        check("rst_hold", {62'b0, rsp_valid, busy}, 64'd0);
        rst_n = 1'b1;
        step();
        send(1'b0, 19'h09, 2'd0, 32'h0, 1'b0, 1'b1, model_rdata(0));
        watch_xfer("rd_after_rst", 1'b0, 19'h09, 0, 32'h0, 1'b0);
        step();

`ifdef CW305_USB_HOST_TRIGGER_EN
        // Flagged two-byte write: trigger high across all eight bus cycles.
        send(1'b1, 19'h06, 2'd1, 32'h0000_BEEF, 1'b1, 1'b1, 32'h0);
        watch_xfer("trig", 1'b1, 19'h06, 1, 32'h0000_BEEF, 1'b1);
        step();
        send(1'b1, 19'h06, 2'd1, 32'h0000_CAFE, 1'b0, 1'b1, 32'h0);
        watch_xfer("notrig", 1'b1, 19'h06, 1, 32'h0000_CAFE, 1'b0);
        step();
`endif

        repeat (3) step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
